// File: rtl/battleship_pkg.sv
// Shared board definitions: cell codes, board size, error codes and the
// placement sequencer state encoding.
package battleship_pkg;

  localparam int unsigned BOARD_DIM = 10;

  // Cell codes stored in the board RAM
  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] MISS  = 2'd1;
  localparam logic [1:0] HIT   = 2'd2;
  localparam logic [1:0] SHIP  = 2'd3;

  // err_code values
  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_BOUNDS  = 2'b01;
  localparam logic [1:0] ERR_OVERLAP = 2'b10;

  typedef enum logic [2:0] {
    StIdle,
    StBounds,
    StScan,
    StScanLast,
    StWrite,
    StDone,
    StError
  } state_e;

endpackage

// File: rtl/ship_placer_if.sv
// Request/status and board-RAM port A bundle for ship_placer.
// The undo request only exists when SHIP_PLACER_UNDO_EN is defined.
interface ship_placer_if;

  logic       start;
  logic [7:0] cursor;
  logic       orient;
  logic [2:0] ship_len;
`ifdef SHIP_PLACER_UNDO_EN
  logic       undo;
`endif
  logic       busy;
  logic       done;
  logic       err;
  logic [1:0] err_code;
  logic [9:0] ram_addr;
  logic       ram_we;
  logic [1:0] ram_wdata;
  logic [1:0] ram_rdata;

`ifdef SHIP_PLACER_UNDO_EN
  modport master (
    output start, cursor, orient, ship_len, undo, ram_rdata,
    input  busy, done, err, err_code, ram_addr, ram_we, ram_wdata
  );
  modport slave (
    input  start, cursor, orient, ship_len, undo, ram_rdata,
    output busy, done, err, err_code, ram_addr, ram_we, ram_wdata
  );
`else
  modport master (
    output start, cursor, orient, ship_len, ram_rdata,
    input  busy, done, err, err_code, ram_addr, ram_we, ram_wdata
  );
  modport slave (
    input  start, cursor, orient, ship_len, ram_rdata,
    output busy, done, err, err_code, ram_addr, ram_we, ram_wdata
  );
`endif

endinterface

// File: rtl/cell_addr_gen.sv
// Combinational board address of ship cell idx_i, counted from the bow
// cell along the given orientation.
module cell_addr_gen (
  input  logic [7:0] cursor_i,
  input  logic       orient_i,
  input  logic [2:0] idx_i,
  output logic [9:0] addr_o
);

  logic [3:0] x, y;

  // Step x for horizontal ships, y for vertical ones
  always_comb begin
    x      = cursor_i[7:4] + (orient_i ? 4'd0 : {1'b0, idx_i});
    y      = cursor_i[3:0] + (orient_i ? {1'b0, idx_i} : 4'd0);
    addr_o = {2'b00, x, y};
  end

endmodule

// File: rtl/ship_placer.sv
// Places one ship into the board RAM through port A: bounds check, occupancy
// scan, then SHIP writes. All outputs are registered from next-state values.
// Optional feature macro: SHIP_PLACER_UNDO_EN (undo of the last placement).
module ship_placer import battleship_pkg::*; #(
  parameter int unsigned BOARD_DIM = battleship_pkg::BOARD_DIM,
  parameter int unsigned MIN_LEN   = 2,
  parameter int unsigned MAX_LEN   = 5
) (
  input  logic           clk,
  input  logic           rst,
  ship_placer_if.slave   bus
);

  localparam logic [4:0] DimW    = 5'(BOARD_DIM);
  localparam logic [2:0] MinLenW = 3'(MIN_LEN);
  localparam logic [2:0] MaxLenW = 3'(MAX_LEN);

  state_e     state_q, state_d;
  logic [2:0] idx_q, idx_d;
  logic       overlap_q, overlap_d;
  logic [7:0] cursor_q, cursor_d;
  logic       orient_q, orient_d;
  logic [2:0] len_q, len_d;
  logic [9:0] addr_q, addr_d;
  logic       we_q, we_d;
  logic [1:0] wdata_q, wdata_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic       err_q, err_d;
  logic [1:0] err_code_q, err_code_d;
`ifdef SHIP_PLACER_UNDO_EN
  logic       undo_q, undo_d;
  logic [7:0] last_cursor_q, last_cursor_d;
  logic       last_orient_q, last_orient_d;
  logic [2:0] last_len_q, last_len_d;
  logic       last_valid_q, last_valid_d;
`endif

  logic [3:0] coord;
  logic [4:0] tail;
  logic       bounds_bad;
  logic [2:0] last_idx;
  logic [9:0] gen_addr;

  // Address of the cell the next cycle will touch, from next-state request
  cell_addr_gen u_addr_gen (
    .cursor_i (cursor_d),
    .orient_i (orient_d),
    .idx_i    (idx_d),
    .addr_o   (gen_addr)
  );

  // Bounds check on the latched request; tail is 5 bits wide so it cannot wrap
  always_comb begin
    coord      = orient_q ? cursor_q[3:0] : cursor_q[7:4];
    tail       = {1'b0, coord} + {2'b00, len_q} - 5'd1;
    bounds_bad = (len_q < MinLenW) || (len_q > MaxLenW) ||
                 ({1'b0, cursor_q[7:4]} >= DimW) || ({1'b0, cursor_q[3:0]} >= DimW) ||
                 (tail >= DimW);
    last_idx   = len_q - 3'd1;
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d    = state_q;
    idx_d      = idx_q;
    overlap_d  = overlap_q;
    cursor_d   = cursor_q;
    orient_d   = orient_q;
    len_d      = len_q;
    err_code_d = err_code_q;
`ifdef SHIP_PLACER_UNDO_EN
    undo_d        = undo_q;
    last_cursor_d = last_cursor_q;
    last_orient_d = last_orient_q;
    last_len_d    = last_len_q;
    last_valid_d  = last_valid_q;
`endif

    unique case (state_q)
      StIdle: begin
        if (bus.start) begin
          cursor_d   = bus.cursor;
          orient_d   = bus.orient;
          len_d      = bus.ship_len;
          idx_d      = 3'd0;
          overlap_d  = 1'b0;
          err_code_d = ERR_NONE;
`ifdef SHIP_PLACER_UNDO_EN
          undo_d     = 1'b0;
`endif
          state_d    = StBounds;
        end
`ifdef SHIP_PLACER_UNDO_EN
        else if (bus.undo) begin
          if (last_valid_q) begin
            cursor_d = last_cursor_q;
            orient_d = last_orient_q;
            len_d    = last_len_q;
            idx_d    = 3'd0;
            undo_d   = 1'b1;
            state_d  = StBounds;
          end else begin
            err_code_d = ERR_BOUNDS;
            state_d    = StError;
          end
        end
`endif
      end
      StBounds: begin
        idx_d = 3'd0;
`ifdef SHIP_PLACER_UNDO_EN
        // A recorded ship was already checked; an undo skips straight to WRITE
        if (undo_q) begin
          state_d = StWrite;
        end else
`endif
        if (bounds_bad) begin
          err_code_d = ERR_BOUNDS;
          state_d    = StError;
        end else begin
          state_d = StScan;
        end
      end
      StScan: begin
        // Read data lags the address by one cycle: this is cell idx_q-1
        if (idx_q != 3'd0 && bus.ram_rdata != EMPTY) overlap_d = 1'b1;
        if (idx_q == last_idx) state_d = StScanLast;
        else                   idx_d   = idx_q + 3'd1;
      end
      StScanLast: begin
        if (overlap_q || bus.ram_rdata != EMPTY) begin
          err_code_d = ERR_OVERLAP;
          state_d    = StError;
        end else begin
          idx_d   = 3'd0;
          state_d = StWrite;
        end
      end
      StWrite: begin
        if (idx_q == last_idx) begin
          state_d = StDone;
`ifdef SHIP_PLACER_UNDO_EN
          if (undo_q) begin
            last_valid_d = 1'b0;
          end else begin
            last_cursor_d = cursor_q;
            last_orient_d = orient_q;
            last_len_d    = len_q;
            last_valid_d  = 1'b1;
          end
`endif
        end else begin
          idx_d = idx_q + 3'd1;
        end
      end
      default: state_d = StIdle;  // StDone, StError
    endcase

    we_d    = (state_d == StWrite);
`ifdef SHIP_PLACER_UNDO_EN
    wdata_d = we_d ? (undo_d ? EMPTY : SHIP) : EMPTY;
`else
    wdata_d = we_d ? SHIP : EMPTY;
`endif
    addr_d  = (state_d == StScan || state_d == StWrite) ? gen_addr : addr_q;
    busy_d  = (state_d != StIdle);
    done_d  = (state_d == StDone);
    err_d   = (state_d == StError);
  end

  // State, request and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      idx_q      <= 3'd0;
      overlap_q  <= 1'b0;
      cursor_q   <= 8'd0;
      orient_q   <= 1'b0;
      len_q      <= 3'd0;
      addr_q     <= 10'd0;
      we_q       <= 1'b0;
      wdata_q    <= EMPTY;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
      err_code_q <= ERR_NONE;
`ifdef SHIP_PLACER_UNDO_EN
      undo_q        <= 1'b0;
      last_cursor_q <= 8'd0;
      last_orient_q <= 1'b0;
      last_len_q    <= 3'd0;
      last_valid_q  <= 1'b0;
`endif
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      overlap_q  <= overlap_d;
      cursor_q   <= cursor_d;
      orient_q   <= orient_d;
      len_q      <= len_d;
      addr_q     <= addr_d;
      we_q       <= we_d;
      wdata_q    <= wdata_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
      err_code_q <= err_code_d;
`ifdef SHIP_PLACER_UNDO_EN
      undo_q        <= undo_d;
      last_cursor_q <= last_cursor_d;
      last_orient_q <= last_orient_d;
      last_len_q    <= last_len_d;
      last_valid_q  <= last_valid_d;
`endif
    end
  end

  assign bus.ram_addr  = addr_q;
  assign bus.ram_we    = we_q;
  assign bus.ram_wdata = wdata_q;
  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.err       = err_q;
  assign bus.err_code  = err_code_q;

endmodule

// File: tb/tb_ship_placer.sv
// Directed bench for ship_placer with a behavioural dual-port board RAM
// (port A only). Cycle 1 is the cycle after the edge that samples start.
module tb_ship_placer;

  logic clk;
  logic rst;
  ship_placer_if bus ();

  ship_placer u_dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Board RAM port A: synchronous write, 1-cycle registered read
  logic [1:0] mem [1024];
  logic       clr, pre_we;
  logic [9:0] pre_addr;
  logic [1:0] pre_data;

  always @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 2'd0;
    end else if (pre_we) begin
      mem[pre_addr] <= pre_data;
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_wdata;
    end
    bus.ram_rdata <= mem[bus.ram_addr];
  end

  int errors = 0;
  int checks = 0;

  int         done_cyc, err_cyc, wr_cnt, first_wr;
  logic [9:0] first_addr, last_addr;
  logic [1:0] wd;
  int         busy_bad;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic start_req(input logic [7:0] c, input logic o, input logic [2:0] l);
    bus.cursor   = c;
    bus.orient   = o;
    bus.ship_len = l;
    bus.start    = 1'b1;
    tick();
    bus.start    = 1'b0;
  endtask

  // Observe cycles 1.. until done/err (bounded); poke > 0 pulses a stray start
  task automatic watch(input int poke);
    done_cyc = 0; err_cyc = 0; wr_cnt = 0; first_wr = 0;
    first_addr = '0; last_addr = '0; wd = '0; busy_bad = 0;
    for (int c = 1; c <= 40; c++) begin
      if (c == poke) begin
        bus.start    = 1'b1;
        bus.cursor   = 8'h00;
        bus.ship_len = 3'd2;
      end else begin
        bus.start = 1'b0;
      end
      if (bus.busy !== 1'b1) busy_bad++;
      if (bus.ram_we === 1'b1) begin
        if (wr_cnt == 0) begin
          first_wr   = c;
          first_addr = bus.ram_addr;
        end
        last_addr = bus.ram_addr;
        wd        = bus.ram_wdata;
        wr_cnt++;
      end
      if (bus.done === 1'b1) begin
        done_cyc = c;
        break;
      end
      if (bus.err === 1'b1) begin
        err_cyc = c;
        break;
      end
      tick();
    end
    bus.start = 1'b0;
    tick();
  endtask

  initial begin
    rst = 1'b1; clr = 1'b1; pre_we = 1'b0; pre_addr = '0; pre_data = '0;
    bus.start = 1'b0; bus.cursor = '0; bus.orient = 1'b0; bus.ship_len = '0;
`ifdef SHIP_PLACER_UNDO_EN
    bus.undo = 1'b0;
`endif
    tick();
    tick();
    chk("rst_addr", bus.ram_addr, 0);
    chk("rst_we", bus.ram_we, 0);
    chk("rst_wdata", bus.ram_wdata, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_err", bus.err, 0);
    chk("rst_code", bus.err_code, 0);
    rst = 1'b0; clr = 1'b0;
    tick();

    // Horizontal len 3 at (2,3)
    start_req(8'h23, 1'b0, 3'd3);
    watch(0);
    chk("t1_done_cyc", done_cyc, 9);
    chk("t1_err_cyc", err_cyc, 0);
    chk("t1_wr_cnt", wr_cnt, 3);
    chk("t1_first_wr", first_wr, 6);
    chk("t1_first_addr", first_addr, 10'h023);
    chk("t1_last_addr", last_addr, 10'h043);
    chk("t1_wdata", wd, 2'd3);
    chk("t1_busy", busy_bad, 0);
    chk("t1_mem033", mem[10'h033], 2'd3);
    chk("t1_idle_busy", bus.busy, 0);
    chk("t1_idle_done", bus.done, 0);

    // Off the right edge
    start_req(8'h81, 1'b0, 3'd3);
    watch(0);
    chk("t2_err_cyc", err_cyc, 2);
    chk("t2_code", bus.err_code, 2'b01);
    chk("t2_wr_cnt", wr_cnt, 0);
    chk("t2_idle_err", bus.err, 0);

    // Overlap with a preloaded HIT at (5,3)
    pre_addr = 10'h053; pre_data = 2'd2; pre_we = 1'b1;
    tick();
    pre_we = 1'b0;
    start_req(8'h50, 1'b1, 3'd4);
    watch(0);
    chk("t3_err_cyc", err_cyc, 7);
    chk("t3_code", bus.err_code, 2'b10);
    chk("t3_wr_cnt", wr_cnt, 0);
    chk("t3_mem050", mem[10'h050], 2'd0);

    // Length limits
    start_req(8'h00, 1'b0, 3'd1);
    watch(0);
    chk("t4_len1_err", err_cyc, 2);
    chk("t4_len1_code", bus.err_code, 2'b01);
    start_req(8'h00, 1'b0, 3'd6);
    watch(0);
    chk("t4_len6_err", err_cyc, 2);
    chk("t4_len6_code", bus.err_code, 2'b01);
    start_req(8'h05, 1'b1, 3'd5);
    watch(0);
    chk("t4_len5_done", done_cyc, 13);
    chk("t4_len5_wr", wr_cnt, 5);
    chk("t4_len5_first", first_addr, 10'h005);
    chk("t4_len5_last", last_addr, 10'h009);
    chk("t4_len5_code", bus.err_code, 2'b00);

    // Stray start while busy, with changed inputs, is ignored and not queued
    start_req(8'h70, 1'b0, 3'd2);
    watch(3);
    chk("t5_done_cyc", done_cyc, 7);
    chk("t5_first", first_addr, 10'h070);
    chk("t5_last", last_addr, 10'h080);
    tick();
    chk("t5_not_queued", bus.busy, 0);

    // Reset in cycle 4 of a len 2 placement
    start_req(8'h66, 1'b1, 3'd2);
    tick(); tick(); tick();
    chk("t6_busy_before", bus.busy, 1);
    rst = 1'b1;
    #1;
    chk("t6_we_rst", bus.ram_we, 0);
    chk("t6_busy_rst", bus.busy, 0);
    tick();
    rst = 1'b0;
    chk("t6_mem066", mem[10'h066], 2'd0);

    // Reset during the first write cycle
    start_req(8'h66, 1'b1, 3'd2);
    tick(); tick(); tick(); tick();
    chk("t7_we_before", bus.ram_we, 1);
    rst = 1'b1;
    #1;
    chk("t7_we_rst", bus.ram_we, 0);
    tick();
    rst = 1'b0;
    tick();
    chk("t7_mem066", mem[10'h066], 2'd0);

    // Next start after reset is accepted normally
    start_req(8'h66, 1'b1, 3'd2);
    watch(0);
    chk("t8_done_cyc", done_cyc, 7);
    chk("t8_mem067", mem[10'h067], 2'd3);

`ifdef SHIP_PLACER_UNDO_EN
    start_req(8'h11, 1'b1, 3'd2);
    watch(0);
    chk("u_place_done", done_cyc, 7);
    chk("u_place_mem", mem[10'h012], 2'd3);
    bus.undo = 1'b1;
    tick();
    bus.undo = 1'b0;
    watch(0);
    chk("u_done_cyc", done_cyc, 4);
    chk("u_first", first_addr, 10'h011);
    chk("u_last", last_addr, 10'h012);
    chk("u_wdata", wd, 2'd0);
    chk("u_mem011", mem[10'h011], 2'd0);
    chk("u_mem012", mem[10'h012], 2'd0);
    bus.undo = 1'b1;
    tick();
    bus.undo = 1'b0;
    watch(0);
    chk("u2_err_cyc", err_cyc, 1);
    chk("u2_code", bus.err_code, 2'b01);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
